// File: rtl/pulse_counter_ctrl.sv
// pulse_counter_ctrl: sequences SCLR/INC/LOAD/DONE for a gated pulse counter,
// counting synchronised PULSE_IN rising edges over a fixed window with saturation.
module pulse_counter_ctrl #(
   parameter int WINDOW_CYCLES = 30,
   parameter int CNT_WIDTH     = 5,
   parameter int SYNC_STAGES   = 2
) (
   input  logic SYS_CLK,
   input  logic RST_N,
   input  logic START,
   input  logic ABORT,
   input  logic PULSE_IN,
   output logic SCLR,
   output logic INC,
   output logic LOAD,
   output logic BUSY,
   output logic DONE,
   output logic OVF
);
   localparam int WW = $clog2(WINDOW_CYCLES + 1);
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_LOAD, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [WW-1:0]          win_q, win_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   sclr_q, sclr_d, inc_q, inc_d, load_q, load_d;
   logic                   busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic                   rise, edge_ok, sat;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], PULSE_IN};
      prev_d  = sync_q[SYNC_STAGES-1];
      rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
      state_d = state_q;
      win_d   = win_q;
      case (state_q)
         S_IDLE:  state_d = START ? S_CLEAR : S_IDLE;
         S_CLEAR: state_d = ABORT ? S_IDLE : S_COUNT;
         S_COUNT: begin
            state_d = ABORT ? S_IDLE : (win_q == WIN_LAST ? S_LOAD : S_COUNT);
            win_d   = win_q + 1'b1;
         end
         S_LOAD:  state_d = ABORT ? S_IDLE : S_DONE;
         S_DONE:  state_d = START ? S_CLEAR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // an edge only counts when COUNT persists, so INC never overlaps LOAD
      edge_ok = rise && state_q == S_COUNT && state_d == S_COUNT;
      sat     = cnt_q == CNT_MAX;
      inc_d   = edge_ok && !sat;
      cnt_d   = state_d == S_CLEAR ? '0 : cnt_q + CNT_WIDTH'(inc_d);
      ovf_d   = state_d == S_CLEAR ? 1'b0 : ovf_q | (edge_ok & sat);
      if (state_d == S_CLEAR) win_d = '0;
      sclr_d  = state_d == S_CLEAR;
      load_d  = state_d == S_LOAD;
      done_d  = state_d == S_DONE;
      busy_d  = state_d == S_CLEAR || state_d == S_COUNT || state_d == S_LOAD;
   end

   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         sync_q  <= '0;
         prev_q  <= 1'b0;
         win_q   <= '0;
         cnt_q   <= '0;
         sclr_q  <= 1'b0;
         inc_q   <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         sclr_q  <= sclr_d;
         inc_q   <= inc_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign SCLR = sclr_q;
   assign INC  = inc_q;
   assign LOAD = load_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign OVF  = ovf_q;
endmodule

// File: tb/tb_pulse_counter_ctrl.sv
// tb_pulse_counter_ctrl: two instances (30- and 200-cycle windows) on shared inputs,
// checked every cycle against a window-arithmetic reference model.
module tb_pulse_counter_ctrl;
   localparam int CMAX = 31;

   logic SYS_CLK = 1'b0, RST_N = 1'b0, START = 1'b0, ABORT = 1'b0, PULSE_IN = 1'b0;
   logic [1:0] sclr, inc, load, busy, done, ovf;

   int compared = 0, mismatched = 0;
   int e = 0;
   logic p [0:8191];
   int   m_st [2];
   int   m_cnt [2];
   logic m_ovf [2];
   logic m_inc [2];
   int inc_seen [2], load_seen [2], done_seen [2], out_reg [2], dp_cnt [2];

   pulse_counter_ctrl #(.WINDOW_CYCLES(30)) u_a (
      .SYS_CLK(SYS_CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .PULSE_IN(PULSE_IN),
      .SCLR(sclr[0]), .INC(inc[0]), .LOAD(load[0]), .BUSY(busy[0]), .DONE(done[0]), .OVF(ovf[0]));
   pulse_counter_ctrl #(.WINDOW_CYCLES(200)) u_b (
      .SYS_CLK(SYS_CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .PULSE_IN(PULSE_IN),
      .SCLR(sclr[1]), .INC(inc[1]), .LOAD(load[1]), .BUSY(busy[1]), .DONE(done[1]), .OVF(ovf[1]));

   always #5 SYS_CLK = ~SYS_CLK;

   function automatic int wof(input int i);
      return (i != 0) ? 200 : 30;
   endfunction

   function automatic logic pv(input int k);
      return (k < 1) ? 1'b0 : p[k];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
      compared++;
      assert (obs === ex) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
      end
   endtask

   // Measurement = start edge s; phase d = edge - s: 0 clear, 1..W count, W+1 load, W+2 done.
   task automatic model_edge();
      e++;
      p[e] = RST_N & PULSE_IN;
      for (int i = 0; i < 2; i++) begin
         int w, d;
         w = wof(i);
         m_inc[i] = 1'b0;
         if (!RST_N) begin
            m_st[i] = -1; m_cnt[i] = 0; m_ovf[i] = 1'b0;
         end else if (m_st[i] >= 0 && e - 1 - m_st[i] <= w + 1 && ABORT) m_st[i] = -1;
         else if ((m_st[i] < 0 || e - 1 - m_st[i] == w + 2) && START) begin
            m_st[i] = e; m_cnt[i] = 0; m_ovf[i] = 1'b0;
         end else if (m_st[i] >= 0 && e - 1 - m_st[i] == w + 2) m_st[i] = -1;
         else if (m_st[i] >= 0) begin
            d = e - m_st[i];
            if (d >= 2 && d <= w && pv(e - 2) && !pv(e - 3)) begin
               if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
               else begin m_cnt[i]++; m_inc[i] = 1'b1; end
            end
         end
      end
   endtask

   task automatic check();
      for (int i = 0; i < 2; i++) begin
         int d, w;
         logic [5:0] ex, ob;
         w  = wof(i);
         d  = e - m_st[i];
         ex = (m_st[i] < 0) ? {5'b0, m_ovf[i]} :
              {d == 0, m_inc[i], d == w + 1, d <= w + 1, d == w + 2, m_ovf[i]};
         ob = {sclr[i], inc[i], load[i], busy[i], done[i], ovf[i]};
         chk($sformatf("outs_dut%0d_edge%0d", i, e), 32'(ob), 32'(ex));
         if (sclr[i]) dp_cnt[i] = 0;
         if (inc[i]) begin dp_cnt[i]++; inc_seen[i]++; end
         if (load[i]) begin out_reg[i] = dp_cnt[i]; load_seen[i]++; end
         if (done[i]) done_seen[i]++;
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic pl);
      START = st; ABORT = ab; PULSE_IN = pl;
      @(posedge SYS_CLK);
      model_edge();
      #1;
      check();
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 2; i++) begin inc_seen[i] = 0; load_seen[i] = 0; done_seen[i] = 0; end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_st[0] >= 0 || m_st[1] >= 0) && n < 500) begin
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         n++;
      end
      chk("wait_idle_budget", 32'(n < 500), 32'd1);
   endtask

   initial begin
      int n, prev_out;
      for (int i = 0; i < 2; i++) begin
         m_st[i] = -1; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_inc[i] = 1'b0;
         out_reg[i] = 0; dp_cnt[i] = 0;
      end
      clear_seen();
      // power-on reset, then a quiet release
      repeat (3) step(1'b0, 1'b0, 1'b0);
      RST_N = 1'b1;
      repeat (10) step(1'b0, 1'b0, 1'b0);
      chk("release_quiet", 32'(load_seen[0] + done_seen[0] + inc_seen[0] + busy[0]), 32'd0);
      // normal window: 10 pulses, 1 high / 2 low
      clear_seen();
      step(1'b1, 1'b0, 1'b0);
      chk("normal_sclr", 32'(sclr[0]), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("normal_load_n32", 32'(load[0]), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("normal_done_n33", 32'(done[0]), 32'd1);
      chk("normal_ovf", 32'(ovf[0]), 32'd0);
      chk("normal_inc_count", 32'(inc_seen[0]), 32'd10);
      chk("normal_out_reg", 32'(out_reg[0]), 32'd10);
      // saturation on the 200-cycle window: 40 pulses
      wait_idle();
      clear_seen();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); end
      n = 0;
      while (!done[1] && n < 300) begin step(1'b0, 1'b0, 1'b0); n++; end
      chk("sat_done_seen", 32'(done[1]), 32'd1);
      chk("sat_ovf_at_done", 32'(ovf[1]), 32'd1);
      chk("sat_inc_count", 32'(inc_seen[1]), 32'd31);
      chk("sat_out_reg", 32'(out_reg[1]), 32'd31);
      step(1'b1, 1'b0, 1'b0);
      chk("sat_restart_sclr", 32'(sclr[1]), 32'd1);
      chk("sat_ovf_cleared", 32'(ovf[1]), 32'd0);
      step(1'b0, 1'b1, 1'b0);
      // abort at COUNT cycle 10
      wait_idle();
      clear_seen();
      prev_out = out_reg[0];
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'(i % 2 == 0));
      step(1'b0, 1'b1, 1'b0);
      chk("abort_busy_low", 32'(busy[0]), 32'd0);
      repeat (50) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("abort_no_load", 32'(load_seen[0]), 32'd0);
      chk("abort_no_done", 32'(done_seen[0]), 32'd0);
      chk("abort_out_reg_kept", 32'(out_reg[0]), 32'(prev_out));
      // held PULSE_IN and back-to-back windows
      wait_idle();
      step(1'b0, 1'b0, 1'b0);
      clear_seen();
      repeat (33) step(1'b1, 1'b0, 1'b1);
      chk("held_done", 32'(done[0]), 32'd1);
      chk("held_one_inc", 32'(inc_seen[0]), 32'd1);
      step(1'b1, 1'b0, 1'b1);
      chk("b2b_sclr_after_done", 32'(sclr[0]), 32'd1);
      clear_seen();
      n = 0;
      while (!done[0] && n < 40) begin step(1'b0, 1'b0, 1'b1); n++; end
      chk("b2b_done_seen", 32'(done[0]), 32'd1);
      chk("b2b_no_new_edge", 32'(inc_seen[0]), 32'd0);
      // async reset at COUNT cycle 5
      step(1'b0, 1'b1, 1'b0);
      wait_idle();
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      RST_N = 1'b0;
      #1;
      chk("async_rst_outs", 32'({sclr, inc, load, busy, done, ovf}), 32'd0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      RST_N = 1'b1;
      clear_seen();
      repeat (40) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("post_rst_no_load", 32'(load_seen[0] + load_seen[1]), 32'd0);
      chk("post_rst_no_done", 32'(done_seen[0] + done_seen[1]), 32'd0);
      // randomized traffic against the model
      repeat (800) step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 60) == 0),
                        1'($urandom_range(0, 2) == 0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
